// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write arbiter
package fifo_arb_pkg;

    // Widest requester vector the helpers need to cover
    localparam int MAX_REQ = 16;

    // Arbiter control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } arb_state_e;

    // One-hot vector with bit idx set; all zero when idx is outside 0..n-1
    function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
        logic [MAX_REQ-1:0] v;
        v = {{(MAX_REQ-1){1'b0}}, 1'b1};
        if (idx >= 0 && idx < n && idx < MAX_REQ) begin
            v = v << idx;
        end else begin
            v = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_sel,
    output logic          o_valid
);

    logic [N-1:0] w_rot;
    logic [IW:0]  w_sum;

    // Rotate so that the pointer position lands on bit 0
    assign w_rot = N'({i_req, i_req} >> i_ptr);

    // Lowest set bit of the rotated vector wins; map it back to an absolute index
    always_comb begin
        o_sel   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, i_ptr} + (IW+1)'(k);
                if (w_sum >= (IW+1)'(N)) begin
                    w_sum = w_sum - (IW+1)'(N);
                end
                o_sel   = w_sum[IW-1:0];
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            gnt,
    output logic                        fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]       fifo_data_in,
    input  logic                        fifo_full,
    input  logic                        fifo_almostfull,
    input  logic                        fifo_wr_ack,
    input  logic                        fifo_overflow,
    output logic [N_REQ-1:0]            done_ack,
    output logic                        err_overflow,
    output logic                        busy
);

    localparam int TW = $clog2(N_REQ);

    logic [N_REQ-1:0]      r_gnt;
    logic                  r_wr_en;
    logic [FIFO_WIDTH-1:0] r_data;
    logic [TW-1:0]         r_ptr;
    logic [TW-1:0]         r_tag;
    logic                  r_tag_vld;
    logic [TW-1:0]         r_ack_tag;
    logic                  r_ack_vld;
    logic                  r_err;
    arb_state_e            r_state;

    logic                  w_can_issue;
    logic [TW-1:0]         w_sel;
    logic                  w_sel_vld;
    logic                  w_grant;
    logic [TW-1:0]         w_next_ptr;
    logic [FIFO_WIDTH-1:0] w_sel_data;
    logic                  w_ack_hit;
    arb_state_e            w_state_nxt;

    // A write already registered is not yet in the FIFO count, so almostfull
    // must be treated as full while fifo_wr_en is high. Reads are ignored.
    assign w_can_issue = enable && !fifo_full && !(fifo_almostfull && r_wr_en);

    rr_arbiter #(
        .N(N_REQ)
    ) u_rr (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_sel   (w_sel),
        .o_valid (w_sel_vld)
    );

    assign w_grant    = w_sel_vld && w_can_issue;
    assign w_next_ptr = (w_sel == TW'(N_REQ - 1)) ? '0 : w_sel + TW'(1);

    // Data mux for the selected requester slice
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel == TW'(i)) begin
                w_sel_data = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    // Grant, write port, pointer and tag pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt     <= '0;
            r_wr_en   <= 1'b0;
            r_data    <= '0;
            r_ptr     <= '0;
            r_tag     <= '0;
            r_tag_vld <= 1'b0;
            r_ack_tag <= '0;
            r_ack_vld <= 1'b0;
        end else begin
            r_wr_en   <= w_grant;
            r_tag_vld <= w_grant;
            r_gnt     <= w_grant ? N_REQ'(onehot(int'(w_sel), N_REQ)) : '0;
            if (w_grant) begin
                r_data <= w_sel_data;
                r_ptr  <= w_next_ptr;
                r_tag  <= w_sel;
            end
            // The FIFO write edge hands the tag over to the ack stage
            r_ack_tag <= r_tag;
            r_ack_vld <= r_tag_vld;
        end
    end

    // Sticky overflow flag raised when the FIFO rejects a write we issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (fifo_overflow && r_ack_vld) begin
            r_err <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: grant wins, otherwise stall while requests wait for space
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ISSUE;
                end else if (|req) begin
                    w_state_nxt = STALL;
                end
            end
            ISSUE: begin
                if (w_grant) begin
                    w_state_nxt = ISSUE;
                end else if (|req) begin
                    w_state_nxt = STALL;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            STALL: begin
                if (w_grant) begin
                    w_state_nxt = ISSUE;
                end else if (!(|req)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A rejected write never produces a completion
    assign w_ack_hit = fifo_wr_ack && r_ack_vld && !fifo_overflow;

    assign gnt          = r_gnt;
    assign fifo_wr_en   = r_wr_en;
    assign fifo_data_in = r_data;
    assign done_ack     = w_ack_hit ? N_REQ'(onehot(int'(r_ack_tag), N_REQ)) : '0;
    assign err_overflow = r_err;
    assign busy         = (r_state == ISSUE) || r_ack_vld;

    a_no_write_into_full: assert property (@(posedge clk) disable iff (!rst_n)
        r_wr_en |-> !fifo_full);

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(r_gnt));

    a_depth_sane: assert property (@(posedge clk) disable iff (!rst_n)
        (FIFO_DEPTH >= 2) && (N_REQ >= 2) && (N_REQ <= MAX_REQ));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 16;
    localparam int D = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_data_in;
    logic           fifo_full;
    logic           fifo_almostfull;
    logic           fifo_wr_ack;
    logic           fifo_overflow;
    logic [N-1:0]   done_ack;
    logic           err_overflow;
    logic           busy;

    logic           rd = 1'b0;
    logic           inj = 1'b0;
    int             m_cnt;
    logic           m_ack;
    logic           m_ovf;
    logic [W-1:0]   m_q[$];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign req_data = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};

    fifo_wr_arbiter #(
        .N_REQ      (N),
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .req             (req),
        .req_data        (req_data),
        .gnt             (gnt),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_data_in    (fifo_data_in),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .fifo_wr_ack     (fifo_wr_ack),
        .fifo_overflow   (fifo_overflow),
        .done_ack        (done_ack),
        .err_overflow    (err_overflow),
        .busy            (busy)
    );

    // FIFO model: registered count, ack and overflow; inj forces a fault
    assign fifo_full       = (m_cnt == D);
    assign fifo_almostfull = (m_cnt == D - 1);
    assign fifo_wr_ack     = m_ack & ~inj;
    assign fifo_overflow   = m_ovf | inj;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_ack <= 1'b0;
            m_ovf <= 1'b0;
            m_q.delete();
        end else begin
            m_ack <= fifo_wr_en && (m_cnt < D);
            m_ovf <= fifo_wr_en && (m_cnt >= D);
            if (rd && m_cnt > 0) m_q.delete(0);
            if (fifo_wr_en && m_cnt < D) m_q.push_back(fifo_data_in);
            m_cnt <= m_cnt + ((fifo_wr_en && m_cnt < D) ? 1 : 0)
                           - ((rd && m_cnt > 0) ? 1 : 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        rd = 1'b1;
        while (m_cnt != 0 && guard < 20) begin
            step();
            guard++;
        end
        rd = 1'b0;
        check("drain_empty", m_cnt, 0);
    endtask

    initial begin
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_ack;
        logic [W-1:0] exp_fifo [6];
        int g2;
        int a2;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_data", fifo_data_in, 0);
        check("rst_done", done_ack, 0);
        check("rst_err", err_overflow, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        enable = 1'b1;

        // All four requesting into an empty FIFO: 0,1,2,3,0,1 with acks one cycle behind
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step();
            exp_gnt = 4'b0001 << (k % 4);
            exp_ack = (k == 0) ? 4'b0000 : (4'b0001 << ((k - 1) % 4));
            check($sformatf("t1_gnt%0d", k), gnt, exp_gnt);
            check($sformatf("t1_data%0d", k), fifo_data_in, 16'h00A0 + 16'(k % 4));
            check($sformatf("t1_ack%0d", k), done_ack, exp_ack);
        end
        // Enable drop: the registered write still completes and is acked
        enable = 1'b0;
        step();
        check("t1_en_off_gnt", gnt, 0);
        check("t1_en_off_ack", done_ack, 4'b0010);
        check("t1_en_off_busy", busy, 1);
        step();
        check("t1_idle_ack", done_ack, 0);
        check("t1_idle_busy", busy, 0);
        exp_fifo = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A0, 16'h00A1};
        check("t1_level", m_q.size(), 6);
        for (int i = 0; i < 6 && i < m_q.size(); i++) begin
            check($sformatf("t1_fifo%0d", i), m_q[i], exp_fifo[i]);
        end
        req = '0;
        enable = 1'b1;
        drain();

        // Sole requester 2 for 10 cycles: exactly DEPTH grants, then stall on full
        g2 = 0;
        a2 = 0;
        req = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            step();
            if (gnt[2]) g2++;
            if (done_ack[2]) a2++;
        end
        check("t2_gnt_count", g2, 8);
        check("t2_ack_count", a2, 8);
        check("t2_full", fifo_full, 1);
        check("t2_state", dut.r_state, STALL);
        check("t2_err", err_overflow, 0);
        check("t2_level", m_q.size(), 8);

        // Read from full: grant resumes at pointer (3), not at 0
        req = 4'b1111;
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("t3_blocked_gnt", gnt, 0);
        check("t3_level7", m_cnt, 7);
        step();
        check("t3_resume_gnt", gnt, 4'b1000);
        check("t3_resume_data", fifo_data_in, 16'h00A3);
        step();
        check("t3_af_gnt", gnt, 0);
        check("t3_af_state", dut.r_state, STALL);
        step();
        check("t3_full_gnt", gnt, 0);
        check("t3_full", fifo_full, 1);
        req = '0;

        // Almostfull with req 1 and 3, pointer at 0: single grant to 1 then none
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("t4_level7", m_cnt, 7);
        req = 4'b1010;
        step();
        check("t4_gnt", gnt, 4'b0010);
        step();
        check("t4_no_gnt", gnt, 0);
        step();
        check("t4_full_gnt", gnt, 0);
        check("t4_full", fifo_full, 1);
        check("t4_err", err_overflow, 0);
        req = '0;
        drain();

        // Reset while a write is registered
        req = 4'b1111;
        step();
        check("t5_pre_gnt", gnt, 4'b0100);
        check("t5_pre_wr_en", fifo_wr_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_gnt", gnt, 0);
        check("t5_rst_wr_en", fifo_wr_en, 0);
        check("t5_rst_data", fifo_data_in, 0);
        check("t5_rst_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_rel_ack", done_ack, 0);
        @(negedge clk);
        check("t5_first_gnt", gnt, 4'b0001);
        check("t5_first_ack", done_ack, 0);

        // Fault injection: overflow reported against the in-flight tag
        req = '0;
        step();
        inj = 1'b1;
        #1;
        check("t6_no_done", done_ack, 0);
        @(negedge clk);
        check("t6_err_set", err_overflow, 1);
        inj = 1'b0;
        step();
        step();
        check("t6_err_sticky", err_overflow, 1);
        check("t6_done_quiet", done_ack, 0);
        check("t6_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
